// File: rtl/sc_nco_pkg.sv
// Shared constants, quadrant encoding and quarter-wave table generator for sc_nco.
package sc_pkg;

  localparam int NCO_LAT = 4;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_t;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Half-step offset keeps the table symmetric so folding never needs an extra entry.
  function automatic int qtab_entry(input int asz, input int dsz, input int k);
    real amp;
    real ang;
    amp = real'((1 << (dsz - 1)) - 1);
    ang = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(1 << asz);
    return int'(amp * $sin(ang));
  endfunction

endpackage

// File: rtl/sc_nco_if.sv
// Sample-request / sample-output bundle of sc_nco.
interface sc_nco_if #(
  parameter int PSZ = 32,
  parameter int DSZ = 18
);
  logic                  ena;
  logic [PSZ-1:0]        freq;
  logic                  freq_ld;
  logic [PSZ-1:0]        phs_ofs;
  logic                  sync;
  logic signed [DSZ-1:0] sin;
  logic signed [DSZ-1:0] cos;
  logic                  valid;

  modport master (
    output ena, freq, freq_ld, phs_ofs, sync,
    input  sin, cos, valid
  );

  modport slave (
    input  ena, freq, freq_ld, phs_ofs, sync,
    output sin, cos, valid
  );
endinterface

// File: rtl/sc_nco_qlut.sv
// Quarter-wave sine ROM with two synchronous read ports (one cycle latency).
module sc_qlut
  import sc_pkg::*;
#(
  parameter int ASZ = 10,
  parameter int DSZ = 18
) (
  input  logic           clk,
  input  logic [ASZ-3:0] addr_s,
  input  logic [ASZ-3:0] addr_c,
  output logic [DSZ-2:0] dat_s,
  output logic [DSZ-2:0] dat_c
);

  localparam int N  = 2 ** (ASZ - 2);
  localparam int DW = DSZ - 1;

  typedef logic [DW-1:0] rom_t [N];

  function automatic rom_t build_rom();
    rom_t r;
    for (int k = 0; k < N; k++) begin
      r[k] = DW'(qtab_entry(ASZ, DSZ, k));
    end
    return r;
  endfunction

  localparam rom_t ROM = build_rom();

  always_ff @(posedge clk) begin
    dat_s <= ROM[addr_s];
    dat_c <= ROM[addr_c];
  end

endmodule

// File: rtl/sc_nco.sv
// Sine/cosine NCO: phase accumulator, quarter-wave fold, 4-stage pipeline.
// Build option SC_NCO_DITHER_EN adds LFSR phase dither ahead of the fold.
module sc_nco
  import sc_pkg::*;
#(
  parameter int PSZ = 32,
  parameter int ASZ = 10,
  parameter int DSZ = 18
) (
  input  logic    clk,
  input  logic    reset,
  sc_nco_if.slave bus
);

  localparam int AW = ASZ - 2;
  localparam int TW = PSZ - ASZ;

  logic [PSZ-1:0] acc;
  logic [PSZ-1:0] freq_r;
  logic [PSZ-1:0] a_sel;
  logic [PSZ-1:0] p1;
  logic [PSZ-1:0] pf;
  logic           v1, v2, v3;
  quad_t          q2, q3;
  logic [AW-1:0]  idx;
  logic [AW-1:0]  addr_s, addr_c;
  logic [DSZ-2:0] ds, dc;
  logic signed [DSZ-1:0] ms, mc;

  assign a_sel = bus.sync ? '0 : acc;

`ifdef SC_NCO_DITHER_EN
  localparam int DW = (TW < 16) ? TW : 16;

  logic [15:0]   lfsr;
  logic [DW-1:0] d1;

  // Dither word travels alongside P so it belongs to the same sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
      d1   <= '0;
    end else if (bus.ena) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0000);
      d1   <= lfsr[15 -: DW];
    end
  end

  assign pf = p1 + (PSZ'(d1) << (TW - DW));
`else
  assign pf = p1;
`endif

  logic unused_lsb;
  assign unused_lsb = ^pf[TW-1:0];

  assign idx = pf[PSZ-3:TW];
  assign ms  = $signed({1'b0, ds});
  assign mc  = $signed({1'b0, dc});

  sc_qlut #(
    .ASZ(ASZ),
    .DSZ(DSZ)
  ) u_qlut (
    .clk   (clk),
    .addr_s(addr_s),
    .addr_c(addr_c),
    .dat_s (ds),
    .dat_c (dc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      freq_r    <= '0;
      p1        <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      q2        <= Q0;
      q3        <= Q0;
      addr_s    <= '0;
      addr_c    <= '0;
      bus.sin   <= '0;
      bus.cos   <= '0;
      bus.valid <= 1'b0;
    end else begin
      if (bus.freq_ld) freq_r <= bus.freq;

      // freq_r is read before its update lands, so a same-cycle load waits one advance
      if (bus.ena)       acc <= a_sel + freq_r;
      else if (bus.sync) acc <= '0;

      v1 <= bus.ena;
      if (bus.ena) p1 <= a_sel + bus.phs_ofs;

      // Odd quadrants mirror the table index; cosine is sine shifted by a quadrant
      v2     <= v1;
      q2     <= quad_t'(pf[PSZ-1:PSZ-2]);
      addr_s <= pf[PSZ-2] ? ~idx : idx;
      addr_c <= pf[PSZ-2] ? idx : ~idx;

      v3 <= v2;
      q3 <= q2;

      bus.valid <= v3;
      if (v3) begin
        bus.sin <= (q3 == Q2 || q3 == Q3) ? -ms : ms;
        bus.cos <= (q3 == Q1 || q3 == Q2) ? -mc : mc;
      end
    end
  end

endmodule

// File: tb/tb_sc_nco.sv
// Scoreboard bench for sc_nco (PSZ=32, ASZ=10, DSZ=18, no dither).
module tb_sc_nco;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sc_nco_if #(.PSZ(32), .DSZ(18)) bus ();

  sc_nco #(.PSZ(32), .ASZ(10), .DSZ(18)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int due;
    int s;
    int c;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        rst_q = 1'b1;
  int          last_s = 0;
  int          last_c = 0;
  logic [31:0] m_acc = '0;
  logic [31:0] m_freq = '0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Direct full-circle evaluation at the sample's 10-bit phase index.
  function automatic void model(input logic [31:0] p, output int s, output int c);
    real x;
    x = 2.0 * 3.141592653589793 * (real'(p[31:22]) + 0.5) / 1024.0;
    s = int'(131071.0 * $sin(x));
    c = int'(131071.0 * $cos(x));
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    int   s_act, c_act;
    s_act = int'(bus.sin);
    c_act = int'(bus.cos);
    if (rst_q) begin
      chk("rst_valid", int'(bus.valid), 0);
      chk("rst_sin", s_act, 0);
      chk("rst_cos", c_act, 0);
      last_s = 0;
      last_c = 0;
    end else if (bus.valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=1 expected no sample (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc, e.due);
        chk("sin", s_act, e.s);
        chk("cos", c_act, e.c);
      end
      chk("sin_range", int'((s_act <= 131070) && (s_act >= -131070)), 1);
      chk("cos_range", int'((c_act <= 131070) && (c_act >= -131070)), 1);
      last_s = s_act;
      last_c = c_act;
    end else begin
      if (sb.size() != 0) chk("missing_valid", (sb[0].due <= cyc) ? 1 : 0, 0);
      chk("hold_sin", s_act, last_s);
      chk("hold_cos", c_act, last_c);
    end
  end

  task automatic drive(input bit e, input bit s, input bit ld, input logic [31:0] f,
                       input logic [31:0] o, input bit hand = 1'b0,
                       input int hs = 0, input int hc = 0);
    logic [31:0] a, p;
    exp_t        x;
    int          ms, mc;
    @(negedge clk);
    bus.ena     = e;
    bus.sync    = s;
    bus.freq_ld = ld;
    bus.freq    = f;
    bus.phs_ofs = o;
    if (e) begin
      a = s ? 32'h0 : m_acc;
      p = a + o;
      model(p, ms, mc);
      x.due = cyc + 4;
      x.s   = hand ? hs : ms;
      x.c   = hand ? hc : mc;
      sb.push_back(x);
      m_acc = a + m_freq;
    end else if (s) begin
      m_acc = '0;
    end
    if (ld) m_freq = f;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    bus.ena     = 1'b0;
    bus.sync    = 1'b0;
    bus.freq_ld = 1'b0;
    sb.delete();
    m_acc  = '0;
    m_freq = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ena     = 1'b0;
    bus.sync    = 1'b0;
    bus.freq_ld = 1'b0;
    bus.freq    = '0;
    bus.phs_ofs = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Zero frequency: constant first-quadrant sample
    drive(0, 0, 1, 32'h0, 32'h0);
    repeat (8) drive(1, 0, 0, 32'h0, 32'h0, 1, 402, 131070);

    // Phase offsets into the other quadrants
    repeat (6) drive(1, 0, 0, 32'h0, 32'h4000_0000, 1, 131070, -402);
    repeat (6) drive(1, 0, 0, 32'h0, 32'h8000_0000, 1, -402, -131070);
    repeat (6) drive(1, 0, 0, 32'h0, 32'hC000_0000, 1, -131070, 402);

    // 256-sample period sweep
    drive(0, 1, 1, 32'h0100_0000, 32'h0);
    repeat (260) drive(1, 0, 0, 32'h0, 32'h0);

    // Gapped requests, one table index per sample
    drive(0, 1, 1, 32'h0040_0000, 32'h0);
    repeat (3) begin
      drive(1, 0, 0, 32'h0, 32'h0);
      drive(0, 0, 0, 32'h0, 32'h0);
      drive(1, 0, 0, 32'h0, 32'h0);
      drive(1, 0, 0, 32'h0, 32'h0);
      drive(0, 0, 0, 32'h0, 32'h0);
    end

    // Sync plus freq load on the same launch cycle
    repeat (3) drive(1, 0, 0, 32'h0, 32'h2000_0000);
    drive(1, 1, 1, 32'h0200_0000, 32'h2000_0000);
    repeat (4) drive(1, 0, 0, 32'h0, 32'h2000_0000);

    // Reset with three samples in flight
    drive(0, 1, 1, 32'h0040_0000, 32'h3000_0000);
    repeat (3) drive(1, 0, 0, 32'h0, 32'h3000_0000);
    do_reset();
    drive(0, 0, 1, 32'h0040_0000, 32'h3000_0000);
    repeat (4) drive(1, 0, 0, 32'h0, 32'h3000_0000);
    drive(0, 0, 0, 32'h0, 32'h3000_0000);

    repeat (10) @(negedge clk);
    chk("drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
